booth_mult_sequencer: RTL and testbench
=======================================

// Module: booth_mult_sequencer
// PURPOSE
//  Iterative radix-4 Booth multiplier controller. Accepts a signed operand pair via valid/ready,
//  retires one Booth digit per clock into a 2N-bit accumulator, and returns the full product via valid/ready.
//  It is the area-lean sequential counterpart to the parallel booth_encoder partial-product array.
//  It sits between an issue stage and the writeback of the multiply unit.
// PARAMETERS
//  DATA_WIDTH  32                    operand width N (two's complement), N >= 2
//  NUM_DIGITS  (DATA_WIDTH+1)/2      radix-4 digits per operand; odd N uses a sign-extended multiplier
//  CNT_WIDTH   $clog2(NUM_DIGITS)+1  width of digit counter
// PORTS
//  clk           in   1        single clock; all state updates on rising edge
//  rst_n         in   1        synchronous, active-low reset
//  in_valid      in   1        operand pair valid
//  in_ready      out  1        block can accept operands (high only in IDLE)
//  multiplicand  in   N        signed multiplicand A
//  multiplier    in   N        signed multiplier B
//  out_valid     out  1        product valid (high only in DONE)
//  out_ready     in   1        consumer accepts product
//  product       out  2N       signed A*B, held stable while out_valid
//  busy          out  1        high in CALC or DONE
//  digit_cnt     out  CNT_WIDTH  digits retired for the current operation
// BEHAVIOUR
//  - Reset: any clk edge with rst_n=0 -> state=IDLE, acc/product=0, digit_cnt=0, out_valid=0, busy=0, in_ready=1
//    (combinational from state). Reset wins over every other event, including mid-CALC and mid-DONE; the
//    in-flight operation is discarded and no out_valid is produced.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready: latch A sign-extended to 2N bits; latch shift register
//    S={sign-ext B to 2*NUM_DIGITS bits, 1'b0}; acc=0; digit_cnt=0; go to CALC.
//  - CALC: recode d from S[2:0]: 000/111->0, 001/010->+A, 011->+2A, 100->-2A, 101/110->-A.
//    acc <= acc + (d*A << 2*digit_cnt), all mod 2^(2N); S <= S>>>2 (arithmetic); digit_cnt++.
//    The cycle that retires digit NUM_DIGITS-1 moves to DONE; product <= new acc.
//  - Latency: accept edge + NUM_DIGITS CALC cycles; out_valid is high on the cycle after the last CALC
//    cycle (N=32: 16 CALC cycles, out_valid 17 cycles after the accept edge).
//  - DONE: out_valid=1, product stable. On out_ready go to IDLE, out_valid=0 next cycle. in_ready=0 in
//    DONE; in_valid there is ignored (no overlap; next accept is at the earliest the cycle after the handoff).
//  - in_valid/operands are don't-care outside IDLE; operand changes during CALC have no effect.
//  - Extremes: A=B=-2^(N-1) yields +2^(2N-2) without overflow; all intermediate sums wrap mod 2^(2N).
// CONFIGURATION
//  BOOTH_EARLY_TERM_EN defined: in CALC, if S after the shift is all-zeros or all-ones (all remaining digits
//    are 0), go to DONE that cycle; digit_cnt reports the digits actually retired. Latency = 1 + retired digits.
//  Not defined: always exactly NUM_DIGITS CALC cycles; latency fixed and data-independent.
// TESTING  (N=32 unless noted)
//  1. A=3, B=5 -> product=0x0000_0000_0000_000F; out_valid exactly 17 cycles after accept; digit_cnt=16.
//  2. A=-7, B=6 -> product=0xFFFF_FFFF_FFFF_FFD6; A=0x8000_0000, B=0x8000_0000 -> 0x4000_0000_0000_0000.
//  3. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and product held; in_ready=0 throughout;
//     out_ready=1 -> IDLE next cycle, in_ready=1.
//  4. rst_n=0 for one cycle at CALC digit 7 -> next cycle IDLE, out_valid=0, product=0; new op 2*2 -> 4.
//  5. BOOTH_EARLY_TERM_EN: B=1 or B=-1 (A=9) -> 1 CALC cycle, product=9 / 0xFFFF_FFFF_FFFF_FFF7,
//     digit_cnt=1; without macro the same ops take 16 cycles, same products.
//  6. N=5: exhaustive 32x32 operand pairs back-to-back with random out_ready -> every product == A*B
//     (10-bit signed), one out_valid per accept, no lost or duplicated results.

Source files
------------

// File: rtl/booth_mult_sequencer.sv
// rtl/booth_mult_sequencer.sv - iterative radix-4 Booth multiplier sequencer
//
// Purpose: accepts a signed operand pair, retires one radix-4 Booth digit per
// clock into a 2N-bit accumulator and returns the full signed product.
// Optional macro BOOTH_EARLY_TERM_EN: stop as soon as every remaining digit is 0.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid, in_ready          operand handshake (in_ready high only in IDLE)
//   multiplicand, multiplier    signed N-bit operands A and B
//   out_valid, out_ready        product handshake (out_valid high only in DONE)
//   product                     signed 2N-bit A*B, stable while out_valid
//   busy                        high in CALC or DONE
//   digit_cnt                   Booth digits retired for the current operation

module booth_mult_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = (DATA_WIDTH + 1) / 2,
  parameter int CNT_WIDTH  = $clog2(NUM_DIGITS) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   multiplicand,
  input  logic [DATA_WIDTH-1:0]   multiplier,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    digit_cnt
);

  localparam int PW = 2 * DATA_WIDTH;
  // Multiplier sign-extended to a whole number of digits plus the implicit
  // zero below bit 0 that the first Booth window looks at.
  localparam int SW = 2 * NUM_DIGITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        a_q, a_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [SW-1:0]        s_q, s_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [PW-1:0]        pp;
  logic [PW-1:0]        pp_shifted;
  logic [PW-1:0]        acc_sum;
  logic [SW-1:0]        s_shift;
  logic                 last_digit;

  // Booth recoding of the current 3-bit window into a partial product.
  always_comb begin
    pp = '0;
    unique case (s_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  // Digit k carries weight 4^k; sums wrap modulo 2^(2N) by construction.
  assign pp_shifted = pp << {cnt_q, 1'b0};
  assign acc_sum    = acc_q + pp_shifted;
  assign s_shift    = $signed(s_q) >>> 2;

`ifdef BOOTH_EARLY_TERM_EN
  // An all-zero or all-one window register recodes to nothing but zero digits.
  assign last_digit = (cnt_q == CNT_WIDTH'(NUM_DIGITS - 1)) ||
                      (s_shift == '0) || (s_shift == '1);
`else
  assign last_digit = (cnt_q == CNT_WIDTH'(NUM_DIGITS - 1));
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = PW'($signed(multiplicand));
          s_d     = {(SW-1)'($signed(multiplier)), 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_sum;
        s_d   = s_shift;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (last_digit) begin
          prod_d  = acc_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = prod_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb/tb_booth_mult_sequencer.sv - scoreboard bench for booth_mult_sequencer

module tb_booth_mult_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 32-bit instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] product;
  logic        busy;
  logic [4:0]  digit_cnt;

  // 5-bit instance
  logic        in_valid5 = 1'b0;
  logic        in_ready5;
  logic [4:0]  mcand5 = '0;
  logic [4:0]  mplier5 = '0;
  logic        out_valid5;
  logic        out_ready5 = 1'b1;
  logic [9:0]  product5;
  logic        busy5;
  logic [2:0]  digit_cnt5;

  booth_mult_sequencer #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(mcand), .multiplier(mplier),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .digit_cnt(digit_cnt)
  );

  booth_mult_sequencer #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid5), .in_ready(in_ready5),
    .multiplicand(mcand5), .multiplier(mplier5),
    .out_valid(out_valid5), .out_ready(out_ready5),
    .product(product5), .busy(busy5), .digit_cnt(digit_cnt5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  function automatic logic [9:0] model5(input logic [4:0] a, input logic [4:0] b);
    logic signed [9:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  function automatic int bitb(input logic [31:0] b, input int j);
    if (j < 0) return 0;
    if (j > 31) return int'(b[31]);
    return int'(b[j]);
  endfunction

  // Digits the sequencer retires for multiplier b (radix-4 Booth definition).
  function automatic int retired32(input logic [31:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    int last = 0;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = bitb(b, 2*i-1) + bitb(b, 2*i) - 2 * bitb(b, 2*i+1);
      if (d != 0) last = i;
    end
    return last + 1;
`else
    return 16 + 0 * bitb(b, 0);
`endif
  endfunction

  // ---------------- scoreboards ----------------
  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
    int          digits;
  } exp_t;

  exp_t       q32[$];
  logic [9:0] q5[$];
  int         outs5 = 0;

  initial begin : mon32
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q32.delete();
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          e.prod    = model32(mcand, mplier);
          e.acc_cyc = cyc;
          e.digits  = retired32(mplier);
          q32.push_back(e);
        end
        if (out_valid && !prev_ov) begin
          if (q32.size() == 0) fail("spurious_out_valid32");
          else chk("latency32", 64'(cyc - q32[0].acc_cyc), 64'(1 + q32[0].digits));
        end
        if (out_valid && out_ready && q32.size() != 0) begin
          e = q32.pop_front();
          chk("product32", product, e.prod);
          chk("digit_cnt32", 64'(digit_cnt), 64'(e.digits));
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin : mon5
    logic [9:0] e5;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q5.delete();
      end else begin
        if (in_valid5 && in_ready5) q5.push_back(model5(mcand5, mplier5));
        if (out_valid5 && out_ready5) begin
          outs5++;
          if (q5.size() == 0) fail("spurious_out_valid5");
          else begin
            e5 = q5.pop_front();
            chk("product5", 64'(product5), 64'(e5));
          end
        end
      end
    end
  end

  // out_ready drivers: fixed value or random per cycle.
  logic or_val = 1'b1;
  logic rnd_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready  = rnd_en ? 1'($urandom_range(0, 1)) : or_val;
      out_ready5 = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- drivers ----------------
  task automatic issue32(input logic [31:0] a, input logic [31:0] b);
    mcand = a;
    mplier = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mcand = $urandom;
        mplier = $urandom;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    fail("issue32_timeout");
  endtask

  task automatic issue5(input logic [4:0] a, input logic [4:0] b);
    mcand5 = a;
    mplier5 = b;
    in_valid5 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready5) begin
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        mcand5 = 5'($urandom);
        mplier5 = 5'($urandom);
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid5 = 1'b0;
    fail("issue5_timeout");
  endtask

  task automatic drain32();
    for (int i = 0; i < 500; i++) begin
      if (q32.size() == 0 && in_ready) return;
      @(posedge clk);
      #1;
    end
    fail("drain32_timeout");
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] hold_exp;
    int          seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_digit_cnt", 64'(digit_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed products and extremes
    issue32(32'd3, 32'd5);
    drain32();
    issue32(-32'sd7, 32'd6);
    drain32();
    issue32(32'h8000_0000, 32'h8000_0000);
    drain32();
    issue32(32'd9, 32'd1);
    drain32();
    issue32(32'd9, 32'hFFFF_FFFF);
    drain32();

    // Backpressure in DONE; in_valid there must be ignored
    or_val = 1'b0;
    hold_exp = model32(32'd123, -32'sd456);
    issue32(32'd123, -32'sd456);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    if (!seen) fail("bp_wait_out_valid");
    in_valid = 1'b1;
    mcand = 32'd77;
    mplier = 32'd88;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_product", product, hold_exp);
    end
    in_valid = 1'b0;
    or_val = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Reset while retiring digit 7
    issue32(32'd11, 32'd13);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    issue32(32'd2, 32'd2);
    drain32();

    // Randomised operands with random consumer stalls
    rnd_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue32(pick32(), pick32());
    end
    drain32();
    rnd_en = 1'b0;

    // N=5 exhaustive, back to back, random out_ready
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        issue5(5'(a), 5'(b));
      end
    end
    for (int i = 0; i < 200 && !(q5.size() == 0 && in_ready5); i++) begin
      @(posedge clk);
      #1;
    end
    chk("n5_outputs", 64'(outs5), 64'd1024);
    chk("n5_queue_empty", 64'(q5.size()), 64'd0);
    chk("n32_queue_empty", 64'(q32.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
